// File: rtl/wb_commit_queue_pkg.sv
// Shared constants and commit-entry type for the write-back commit queue.
// REG_T is listed so producers and the register file agree on its code; the queue passes it through untouched.
package wb_commit_queue_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    localparam logic [REG_AW-1:0] REG0  = 4'd0;
    localparam logic [REG_AW-1:0] REG_T = 4'd15;

    typedef struct packed {
        logic [REG_AW-1:0] dst;
        logic [DATA_W-1:0] data;
    } commit_entry_t;

endpackage

// File: rtl/wb_commit_queue_if.sv
// Producer/issue inputs and register-file write-port outputs of the commit queue.
interface wb_commit_queue_if #(
    parameter int DATA_W = wb_commit_queue_pkg::DATA_W,
    parameter int REG_AW = wb_commit_queue_pkg::REG_AW
);
    logic                   IssueValid;
    logic [REG_AW-1:0]      IssueReg;
    logic                   AluValid;
    logic [REG_AW-1:0]      AluReg;
    logic [DATA_W-1:0]      AluData;
    logic                   MemValid;
    logic [REG_AW-1:0]      MemReg;
    logic [DATA_W-1:0]      MemData;
    logic                   InReady;
    logic                   RegWre;
    logic [REG_AW-1:0]      WriteReg;
    logic [DATA_W-1:0]      WriteData;
    logic [2**REG_AW-1:0]   Busy;
    logic                   Empty;

    modport master (
        output IssueValid, IssueReg, AluValid, AluReg, AluData, MemValid, MemReg, MemData,
        input  InReady, RegWre, WriteReg, WriteData, Busy, Empty
    );

    modport slave (
        input  IssueValid, IssueReg, AluValid, AluReg, AluData, MemValid, MemReg, MemData,
        output InReady, RegWre, WriteReg, WriteData, Busy, Empty
    );
endinterface

// File: rtl/wb_fifo2w1r.sv
// Circular buffer taking up to two writes and one read per cycle; write port 0 lands ahead of port 1.
module wb_fifo2w1r
    import wb_commit_queue_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
)(
    input  logic          Clk,
    input  logic          Rst,
    input  logic          wrEn0,
    input  commit_entry_t wrData0,
    input  logic          wrEn1,
    input  commit_entry_t wrData1,
    input  logic          rdEn,
    output commit_entry_t rdData,
    output logic [CW-1:0] count
);

    commit_entry_t   mem [DEPTH];
    logic [AW-1:0]   wrPtr;
    logic [AW-1:0]   wrPtr1;
    logic [AW-1:0]   rdPtr;

    // Port 1 follows port 0 only when port 0 actually writes, so a lone entry never leaves a hole.
    assign wrPtr1 = wrPtr + AW'(wrEn0);
    assign rdData = mem[rdPtr];

    // Storage writes; nothing is written while reset is held.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            if (wrEn0) mem[wrPtr]  <= wrData0;
            if (wrEn1) mem[wrPtr1] <= wrData1;
        end
    end

    // Pointer and occupancy update.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wrPtr <= {AW{1'b0}};
            rdPtr <= {AW{1'b0}};
            count <= {CW{1'b0}};
        end else begin
            wrPtr <= wrPtr + AW'(wrEn0) + AW'(wrEn1);
            rdPtr <= rdPtr + AW'(rdEn);
            count <= count + CW'(wrEn0) + CW'(wrEn1) - CW'(rdEn);
        end
    end

endmodule

// File: rtl/wb_commit_queue.sv
// Orders ALU and load results, drives one register-file write per cycle, and tracks pending writes per register.
module wb_commit_queue #(
    parameter int DATA_W = wb_commit_queue_pkg::DATA_W,
    parameter int REG_AW = wb_commit_queue_pkg::REG_AW,
    parameter int DEPTH  = 4
)(
    input  logic              Clk,
    input  logic              Rst,
    wb_commit_queue_if.slave  bus
);
    import wb_commit_queue_pkg::*;

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int NREG = 2 ** REG_AW;

    logic [CW-1:0]     count;
    logic              pop;
    logic              inReady;
    logic              memOk;
    logic              aluOk;
    commit_entry_t     memEntry;
    commit_entry_t     aluEntry;
    commit_entry_t     head;
    logic              regWre;
    logic [REG_AW-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busyNext;

    // Two free slots guarantee a dual enqueue is never split; valids arriving without them are dropped.
    assign inReady = (count <= CW'(DEPTH - 2));
    assign pop     = (count != {CW{1'b0}});
    assign memOk   = bus.MemValid && inReady && (bus.MemReg != REG0);
    assign aluOk   = bus.AluValid && inReady && (bus.AluReg != REG0);
    assign memEntry = '{dst: bus.MemReg, data: bus.MemData};
    assign aluEntry = '{dst: bus.AluReg, data: bus.AluData};

    // The load was issued earlier, so it takes write port 0.
    wb_fifo2w1r #(.DEPTH(DEPTH)) uFifo (
        .Clk     (Clk),
        .Rst     (Rst),
        .wrEn0   (memOk),
        .wrData0 (memEntry),
        .wrEn1   (aluOk),
        .wrData1 (aluEntry),
        .rdEn    (pop),
        .rdData  (head),
        .count   (count)
    );

    // Write-port register: address and data hold their last values when idle.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            regWre    <= 1'b0;
            writeReg  <= {REG_AW{1'b0}};
            writeData <= {DATA_W{1'b0}};
        end else if (pop) begin
            regWre    <= 1'b1;
            writeReg  <= head.dst;
            writeData <= head.data;
        end else begin
            regWre    <= 1'b0;
        end
    end

    // Scoreboard next state: a fresh issue overrides a same-cycle commit of that register.
    always_comb begin
        busyNext = busy;
        if (regWre) begin
            busyNext[writeReg] = 1'b0;
        end else begin
            busyNext = busy;
        end
        if (bus.IssueValid && (bus.IssueReg != REG0)) begin
            busyNext[bus.IssueReg] = 1'b1;
        end else begin
            busyNext[0] = 1'b0;
        end
        busyNext[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            busy <= {NREG{1'b0}};
        end else begin
            busy <= busyNext;
        end
    end

    assign bus.InReady   = inReady;
    assign bus.RegWre    = regWre;
    assign bus.WriteReg  = writeReg;
    assign bus.WriteData = writeData;
    assign bus.Busy      = busy;
    assign bus.Empty     = (count == {CW{1'b0}}) && !regWre;

endmodule
